// File: rtl/shreg_seq_pkg.sv
// Shared types for the shift-register command sequencer: op/mode encoding and FSM states.
// Op encoding matches the register's mode pins, so a latched op drives reg_mode directly.
package shreg_seq_pkg;

    typedef enum logic [1:0] {
        OP_SISO_R = 2'b00,
        OP_SISO_L = 2'b01,
        OP_PISO   = 2'b10,
        OP_PIPO   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    localparam logic [1:0] MODE_IDLE = 2'b11;

    function automatic logic op_needs_load(input op_e op);
        return (op == OP_PISO) || (op == OP_PIPO);
    endfunction

endpackage

// File: rtl/shreg_seq_collector.sv
// Serial deserializer: gathers one bit per shift into a WIDTH-bit word, MSB- or LSB-side insertion.
// Latency: o_dat_nxt shows the word including the bit being shifted in this cycle; no backpressure.
// Backpressure: none, the sequencer owns the shift strobe.
module shreg_seq_collector
    import shreg_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_dir_left,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_dat_nxt
);

    logic [WIDTH-1:0] r_col;
    logic [WIDTH-1:0] w_shifted;

    // Left mode inserts at the LSB (register emits its MSB first); right mode inserts at the MSB.
    always_comb begin
        w_shifted = r_col;
        if (i_dir_left) begin
            w_shifted = {r_col[WIDTH-2:0], i_bit};
        end else begin
            w_shifted = {i_bit, r_col[WIDTH-1:1]};
        end
    end

    assign o_dat_nxt = i_shift ? w_shifted : r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
        end else if (i_clr) begin
            r_col <= '0;
        end else if (i_shift) begin
            r_col <= w_shifted;
        end
    end

endmodule

// File: rtl/shreg_seq_ctrl.sv
// Command sequencer that is sole master of the 4-mode shift register's control pins.
// Latency accept->rsp_valid: PIPO 3, PISO WIDTH+2, SISO WIDTH+1; one command in flight.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. Option: SHREG_SEQ_CHECK_EN.
module shreg_seq_ctrl
    import shreg_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef SHREG_SEQ_CHECK_EN
    output logic             rsp_mismatch,
`endif
    output logic             busy,
    output logic             reg_enable,
    output logic [1:0]       reg_mode,
    output logic             reg_load,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic             reg_serial_out,
    input  logic [WIDTH-1:0] reg_parallel_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_accept;
    logic             w_shift_last;
    logic             w_col_shift;
    logic [CNT_W-1:0] w_idx_left;
    logic [WIDTH-1:0] w_col_nxt;

    assign w_accept     = cmd_valid && (r_state == ST_IDLE);
    assign w_shift_last = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
    assign w_col_shift  = (r_state == ST_SHIFT);
    assign w_idx_left   = CNT_LAST - r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = op_needs_load(op_e'(cmd_op)) ? ST_LOAD : ST_SHIFT;
                end
            end
            ST_LOAD: begin
                w_state_nxt = (r_op == OP_PIPO) ? ST_CAPTURE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_shift_last) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register pins decode only from registered state so cmd_* never reaches them combinationally.
    always_comb begin
        reg_enable      = 1'b0;
        reg_load        = 1'b0;
        reg_serial_in   = 1'b0;
        reg_parallel_in = '0;
        case (r_state)
            ST_LOAD: begin
                reg_enable      = 1'b1;
                reg_load        = 1'b1;
                reg_parallel_in = r_data;
            end
            ST_SHIFT: begin
                reg_enable = 1'b1;
                case (r_op)
                    OP_SISO_R: reg_serial_in = r_data[r_cnt];
                    OP_SISO_L: reg_serial_in = r_data[w_idx_left];
                    default:   reg_serial_in = 1'b0;
                endcase
            end
            default: begin
                reg_enable = 1'b0;
            end
        endcase
    end

    assign reg_mode  = r_mode;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_rsp_data;

    shreg_seq_collector #(
        .WIDTH (WIDTH)
    ) u_collector (
        .clk        (clk),
        .rst_n      (rst),
        .i_clr      (w_accept),
        .i_shift    (w_col_shift),
        .i_dir_left (r_op == OP_SISO_L),
        .i_bit      (reg_serial_out),
        .o_dat_nxt  (w_col_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= OP_PIPO;
            r_mode     <= MODE_IDLE;
            r_data     <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= op_e'(cmd_op);
                r_mode <= cmd_op;
                r_data <= cmd_data;
                r_cnt  <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_mode <= MODE_IDLE;
            end
            if (r_state == ST_CAPTURE) begin
                r_rsp_data <= reg_parallel_out;
            end else if (w_shift_last) begin
                r_rsp_data <= w_col_nxt;
            end
        end
    end

`ifdef SHREG_SEQ_CHECK_EN
    logic r_mismatch;

    // Only load-based ops have an expected readback equal to the written word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_mismatch <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_mismatch <= (reg_parallel_out != r_data);
        end else if (w_shift_last) begin
            r_mismatch <= (r_op == OP_PISO) && (w_col_nxt != r_data);
        end
    end

    assign rsp_mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Bench for shreg_seq_ctrl with a behavioural 4-mode shift register attached to its pins.
// Expected responses are queued at issue time and popped when the response handshake occurs.
module tb_shreg_seq_ctrl;
    import shreg_seq_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         busy;
    logic         reg_enable;
    logic [1:0]   reg_mode;
    logic         reg_load;
    logic         reg_serial_in;
    logic [W-1:0] reg_parallel_in;
    logic         reg_serial_out;
    logic [W-1:0] reg_parallel_out;
`ifdef SHREG_SEQ_CHECK_EN
    logic         rsp_mismatch;
`endif

    int n_chk = 0;
    int n_err = 0;
    int n_en  = 0;
    int n_ld  = 0;
    logic [W-1:0] exp_reg = '0;
    logic [W-1:0] sb_q[$];

    always #5 clk = ~clk;

    shreg_seq_ctrl #(.WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
`ifdef SHREG_SEQ_CHECK_EN
        .rsp_mismatch     (rsp_mismatch),
`endif
        .busy             (busy),
        .reg_enable       (reg_enable),
        .reg_mode         (reg_mode),
        .reg_load         (reg_load),
        .reg_serial_in    (reg_serial_in),
        .reg_parallel_in  (reg_parallel_in),
        .reg_serial_out   (reg_serial_out),
        .reg_parallel_out (reg_parallel_out)
    );

    // Shift register: right modes emit LSB and take serial_in at MSB, left mode the reverse.
    logic [W-1:0] mdl_reg = '0;
    assign reg_serial_out   = (reg_mode == 2'b01) ? mdl_reg[W-1] : mdl_reg[0];
    assign reg_parallel_out = mdl_reg;

    always @(posedge clk) begin
        if (reg_enable) begin
            if (reg_load) begin
                mdl_reg <= reg_parallel_in;
            end else begin
                case (reg_mode)
                    2'b00, 2'b10: mdl_reg <= {reg_serial_in, mdl_reg[W-1:1]};
                    2'b01:        mdl_reg <= {mdl_reg[W-2:0], reg_serial_in};
                    default:      mdl_reg <= mdl_reg;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (reg_enable) n_en <= n_en + 1;
            if (reg_load)   n_ld <= n_ld + 1;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data, input int hold);
        logic [W-1:0] exp_rsp;
        logic [W-1:0] held;
        int exp_lat, exp_en, exp_ld, lat, en0, ld0;
        bit got;
        case (op)
            2'b11:   begin exp_rsp = data;    exp_lat = 3;     exp_en = 1;     exp_reg = data; end
            2'b10:   begin exp_rsp = data;    exp_lat = W + 2; exp_en = W + 1; exp_reg = '0;   end
            default: begin exp_rsp = exp_reg; exp_lat = W + 1; exp_en = W;     exp_reg = data; end
        endcase
        exp_ld = op[1] ? 1 : 0;
        sb_q.push_back(exp_rsp);
        en0 = n_en;
        ld0 = n_ld;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("cmd_accept", W'(got), W'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_data  = ~data;

        lat = 0;
        got = 1'b0;
        for (int i = 0; i < W + 20; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("rsp_seen", W'(got), W'(1));
        chk("latency", W'(lat), W'(exp_lat));

        if (hold > 0) begin
            held      = rsp_data;
            cmd_valid = 1'b1;
            cmd_op    = 2'b10;
            cmd_data  = {$urandom, $urandom};
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_rsp_valid", W'(rsp_valid), W'(1));
                chk("hold_rsp_data", rsp_data, held);
                chk("hold_cmd_ready", W'(cmd_ready), W'(0));
            end
            cmd_valid = 1'b0;
        end

        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", W'(0), W'(1));
        end else begin
            chk("rsp_data", rsp_data, sb_q.pop_front());
        end
`ifdef SHREG_SEQ_CHECK_EN
        chk("rsp_mismatch", W'(rsp_mismatch), W'(0));
`endif
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_busy", W'(busy), W'(0));
        chk("post_rsp_valid", W'(rsp_valid), W'(0));
        @(negedge clk);
        chk("enable_cycles", W'(n_en - en0), W'(exp_en));
        chk("load_cycles", W'(n_ld - ld0), W'(exp_ld));
        chk("reg_contents", mdl_reg, exp_reg);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] rdat;
        logic [1:0]   rop;

        #23;
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_enable", W'(reg_enable), W'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_load", W'(reg_load), W'(0));
        chk("rst_mode", W'(reg_mode), W'(2'b11));
        chk("rst_serial_in", W'(reg_serial_in), W'(0));
        chk("rst_parallel_in", reg_parallel_in, '0);
        chk("rst_cmd_ready", W'(cmd_ready), W'(1));

        do_cmd(2'b11, 64'hDEADBEEF01234567, 0);
        do_cmd(2'b11, 64'h0123456789ABCDEF, 0);
        do_cmd(2'b00, 64'hA5A5A5A5A5A5A5A5, 0);
        do_cmd(2'b11, 64'h00000000FFFFFFFF, 0);
        do_cmd(2'b01, 64'h8000000000000001, 0);
        do_cmd(2'b10, 64'hCAFEF00D12345678, 0);
        do_cmd(2'b11, 64'h5555AAAA3333CCCC, 10);

        // Abort a right-shift write partway through SHIFT.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 64'hFFFF0000FFFF0000;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 21; k++) @(negedge clk);
        chk("mid_enable_before", W'(reg_enable), W'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_enable", W'(reg_enable), W'(0));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_rsp_valid", W'(rsp_valid), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_no_rsp", W'(rsp_valid), W'(0));
        end
        do_cmd(2'b11, 64'h1, 0);

        for (int r = 0; r < 6; r++) begin
            rop  = 2'($urandom_range(0, 3));
            rdat = {$urandom, $urandom};
            do_cmd(rop, rdat, 0);
        end

        chk("scoreboard_drained", W'(sb_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
